lp_filter_multi: RTL and testbench

LP_FILTER_MULTI -- requirements
Module: lp_filter_multi

---
 rtl/lp_filter_multi.sv | 203 ++++++++++++++++++++
 tb/tb_lp_filter_multi.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lp_filter_multi.sv
// lp_filter_multi: multi-channel one-pole low-pass filter. It uses a shared
// time-multiplexed datapath. An internal prescaler produces the sample tick.
// On each tick the inputs are captured, and a sequencer then updates one
// channel stage per clock: y <= y + ((x - y) >>> k).
//
// Optional feature: define LP_FILTER_SECOND_STAGE_EN to cascade a second
// identical pole per channel (12 dB/oct). This adds one WIDTH-bit register
// per channel.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_sound   CHANNELS*WIDTH packed signed samples, channel c at [c*WIDTH +: WIDTH]
//   shift      pole coefficient k (0 = bypass, 1..15 = weight 2^-k)
//   out_sound  filtered samples, same packing, registered
//   out_valid  one-cycle pulse after all channels are updated for a tick
//   busy       high while the sequencer is stepping through channels
module lp_filter_multi #(
    parameter int unsigned CLK_HZ    = 27000000,
    parameter int unsigned CUTOFF_HZ = 1500,
    parameter int unsigned WIDTH     = 18,
    parameter int unsigned CHANNELS  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_sound,
    input  logic [3:0]                shift,
    output logic [CHANNELS*WIDTH-1:0] out_sound,
    output logic                      out_valid,
    output logic                      busy
);

    localparam int unsigned PRESCALE = CLK_HZ / (CUTOFF_HZ * 32);
`ifdef LP_FILTER_SECOND_STAGE_EN
    localparam int unsigned S = 2;
`else
    localparam int unsigned S = 1;
`endif
    localparam int unsigned STEPS = S * CHANNELS;
    localparam int unsigned IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned CNT_W = $clog2(PRESCALE + 1);
    localparam int unsigned DW    = WIDTH + 1;

    // A tick must never arrive while the sequencer is still busy.
    if (PRESCALE < STEPS + 1) begin : g_prescale_check
        $error("lp_filter_multi: PRESCALE too small for S*CHANNELS steps");
    end

    typedef enum logic {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } state_e;

    // Prescaler: tick in the cycle the counter reads zero, then reload
    logic [CNT_W-1:0] cnt_q;
    logic             tick_c;

    assign tick_c = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CNT_W'(PRESCALE);
        end else if (tick_c) begin
            cnt_q <= CNT_W'(PRESCALE);
        end else begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Sequencer
    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             upd_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        upd_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick_c) begin
                    state_d = UPDATE;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            UPDATE: begin
                upd_c = 1'b1;
                if (idx_q == IDX_W'(STEPS - 1)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    valid_d = 1'b1;
                end else begin
                    idx_d  = idx_q + IDX_W'(1);
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Snapshot of inputs, taken only on tick (the sequencer is idle then)
    logic [CHANNELS*WIDTH-1:0] snap_q;
    logic [3:0]                shift_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q  <= '0;
            shift_q <= '0;
        end else if (tick_c && state_q == IDLE) begin
            snap_q  <= in_sound;
            shift_q <= shift;
        end
    end

    // Step decode: the step index maps to (channel, stage)
    logic [CH_W-1:0] ch_c;
    logic            stage2_c;

    always_comb begin
`ifdef LP_FILTER_SECOND_STAGE_EN
        ch_c     = CH_W'(idx_q >> 1);
        stage2_c = idx_q[0];
`else
        ch_c     = CH_W'(idx_q);
        stage2_c = 1'b0;
`endif
    end

    // Shared subtract / arithmetic shift / add datapath
    logic [CHANNELS*WIDTH-1:0] st1_q;
`ifdef LP_FILTER_SECOND_STAGE_EN
    logic [CHANNELS*WIDTH-1:0] st2_q;
`endif
    logic signed [WIDTH-1:0] x_c, y_c, y_new_c;
    logic signed [DW-1:0]    diff_c, step_c, sum_c;

    always_comb begin
        x_c = snap_q[ch_c*WIDTH +: WIDTH];
        y_c = st1_q[ch_c*WIDTH +: WIDTH];
`ifdef LP_FILTER_SECOND_STAGE_EN
        if (stage2_c) begin
            x_c = st1_q[ch_c*WIDTH +: WIDTH];
            y_c = st2_q[ch_c*WIDTH +: WIDTH];
        end
`endif
        diff_c = {x_c[WIDTH-1], x_c} - {y_c[WIDTH-1], y_c};
        // Kept separate so the shift stays in a signed context (arithmetic).
        step_c  = diff_c >>> shift_q;
        sum_c   = {y_c[WIDTH-1], y_c} + step_c;
        // y moves toward x, so the sum always fits back into WIDTH bits.
        y_new_c = WIDTH'(sum_c);
    end

    // Stage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st1_q <= '0;
        end else if (upd_c && !stage2_c) begin
            st1_q[ch_c*WIDTH +: WIDTH] <= y_new_c;
        end
    end

`ifdef LP_FILTER_SECOND_STAGE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st2_q <= '0;
        end else if (upd_c && stage2_c) begin
            st2_q[ch_c*WIDTH +: WIDTH] <= y_new_c;
        end
    end

    assign out_sound = st2_q;
`else
    assign out_sound = st1_q;
`endif

    assign out_valid = valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_lp_filter_multi.sv
// Testbench for lp_filter_multi with default parameters. Works with or
// without LP_FILTER_SECOND_STAGE_EN defined.
module tb_lp_filter_multi;

    localparam int W   = 18;
    localparam int CH  = 2;
    localparam int PRE = 562;
`ifdef LP_FILTER_SECOND_STAGE_EN
    localparam int S = 2;
`else
    localparam int S = 1;
`endif
    localparam int STEPS = S * CH;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [CH*W-1:0]   in_sound = '0;
    logic [3:0]        shift = '0;
    logic [CH*W-1:0]   out_sound;
    logic              out_valid;
    logic              busy;

    int total = 0;
    int bad   = 0;

    int cur_in[CH];
    int cur_k;
    int m1[CH];
    int m2[CH];

    always #5 clk = ~clk;

    lp_filter_multi dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_sound  (in_sound),
        .shift     (shift),
        .out_sound (out_sound),
        .out_valid (out_valid),
        .busy      (busy)
    );

    // One pole step: y + floor((x - y) / 2^k)
    function automatic int lp_pole(int y, int x, int k);
        int d, p, q;
        d = x - y;
        p = 1 << k;
        if (d >= 0) q = d / p;
        else        q = -((-d + p - 1) / p);
        return y + q;
    endfunction

    task automatic model_tick();
        for (int c = 0; c < CH; c++) begin
            m1[c] = lp_pole(m1[c], cur_in[c], cur_k);
            if (S == 2) m2[c] = lp_pole(m2[c], m1[c], cur_k);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < CH; c++) begin
            m1[c] = 0;
            m2[c] = 0;
        end
    endtask

    function automatic int model_out(int c);
        return (S == 2) ? m2[c] : m1[c];
    endfunction

    function automatic int dut_ch(int c);
        logic signed [W-1:0] v;
        v = out_sound[c*W +: W];
        return int'(v);
    endfunction

    task automatic apply();
        for (int c = 0; c < CH; c++) in_sound[c*W +: W] = W'(cur_in[c]);
        shift = 4'(cur_k);
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_update(output int edges, output int busy_n, output bit ok);
        edges  = 0;
        busy_n = 0;
        ok     = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (busy) busy_n++;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic tick_and_check(input string tag, output bit ok);
        int e, b;
        wait_update(e, b, ok);
        check({tag, "_timeout"}, int'(ok), 1);
        if (ok) begin
            model_tick();
            for (int c = 0; c < CH; c++)
                check($sformatf("%s_ch%0d", tag, c), dut_ch(c), model_out(c));
            check({tag, "_busy"}, b, STEPS);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        model_clear();
        rst_n = 1'b1;
    endtask

    initial begin
        int  e, b;
        bit  ok;
        bit  found;
        int  a028[3];
        a028 = '{125, 234, 329};

        // Reset state
        for (int c = 0; c < CH; c++) cur_in[c] = 0;
        cur_k = 0;
        apply();
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ch0", dut_ch(0), 0);
        check("rst_ch1", dut_ch(1), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);

        // Step response, k = 3, ch1 held at 0
        cur_in[0] = 1000;
        cur_in[1] = 0;
        cur_k     = 3;
        apply();
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tick_and_check($sformatf("step_t%0d", t), ok);
`ifndef LP_FILTER_SECOND_STAGE_EN
            if (ok) check($sformatf("step_const_t%0d", t), dut_ch(0), a028[t]);
`endif
            if (ok) check($sformatf("step_ch1_zero_t%0d", t), dut_ch(1), 0);
        end
        @(posedge clk);
        #1;
        check("valid_one_cycle", int'(out_valid), 0);

        // Reset pulsed in the middle of an update sequence
        found = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            if (busy) begin
                found = 1'b1;
                break;
            end
        end
        check("midrst_busy_seen", int'(found), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_ch0", dut_ch(0), 0);
        check("midrst_ch1", dut_ch(1), 0);
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_busy", int'(busy), 0);
        model_clear();
        cur_in[0] = 1000;
        cur_in[1] = -1000;
        cur_k     = 3;
        apply();
        @(negedge clk);
        rst_n = 1'b1;
        wait_update(e, b, ok);
        check("midrst_first_valid_edges", e, PRE + 1 + STEPS);
        if (ok) begin
            model_tick();
            check("neg_t0_ch0", dut_ch(0), model_out(0));
            check("neg_t0_ch1", dut_ch(1), model_out(1));
`ifndef LP_FILTER_SECOND_STAGE_EN
            check("neg_t0_const", dut_ch(1), -125);
`endif
        end

        // Convergence with input held
        for (int t = 1; t < 50; t++) tick_and_check($sformatf("conv_t%0d", t), ok);
`ifndef LP_FILTER_SECOND_STAGE_EN
        check("conv_neg_exact", dut_ch(1), -1000);
`endif

        // Small differences: 5 < 2^3 never moves, 8 moves by one
        do_reset();
        cur_in[0] = 5;
        cur_in[1] = 8;
        cur_k     = 3;
        apply();
        for (int t = 0; t < 4; t++) begin
            tick_and_check($sformatf("small_t%0d", t), ok);
            if (ok) check($sformatf("small5_t%0d", t), dut_ch(0), 0);
`ifndef LP_FILTER_SECOND_STAGE_EN
            if (ok) check($sformatf("small8_t%0d", t), dut_ch(1), 1);
`endif
        end

        // Bypass at full-scale values, and tick period
        cur_in[0] = 131071;
        cur_in[1] = -131072;
        cur_k     = 0;
        apply();
        tick_and_check("bypass", ok);
        check("bypass_ch0", dut_ch(0), 131071);
        check("bypass_ch1", dut_ch(1), -131072);
        wait_update(e, b, ok);
        check("period_edges", e, PRE + 1);
        if (ok) model_tick();

        // Random: inputs scrambled during busy must be ignored
        for (int t = 0; t < 12; t++) begin
            for (int c = 0; c < CH; c++) cur_in[c] = int'($urandom_range(262143, 0)) - 131072;
            cur_k = int'($urandom_range(15, 0));
            apply();
            found = 1'b0;
            for (int i = 0; i < 1500; i++) begin
                @(posedge clk);
                #1;
                if (busy) begin
                    found = 1'b1;
                    break;
                end
            end
            check($sformatf("rnd_busy_seen_t%0d", t), int'(found), 1);
            in_sound = (CH*W)'({$urandom(), $urandom()});
            shift    = 4'($urandom_range(15, 0));
            wait_update(e, b, ok);
            check($sformatf("rnd_timeout_t%0d", t), int'(ok), 1);
            if (ok) begin
                model_tick();
                for (int c = 0; c < CH; c++)
                    check($sformatf("rnd_t%0d_ch%0d", t, c), dut_ch(c), model_out(c));
            end
        end

`ifdef LP_FILTER_SECOND_STAGE_EN
        // Two-pole cascade, k = 1: stage 1 reaches 500, output reaches 250
        do_reset();
        cur_in[0] = 1000;
        cur_in[1] = 0;
        cur_k     = 1;
        apply();
        tick_and_check("cascade", ok);
        check("cascade_const", dut_ch(0), 250);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
